mass_pass_scheduler: RTL and testbench
======================================

Name: mass_pass_scheduler

Overview:
- Sequences one mass-update pass per audio sample tick over the dual-read/single-write state RAM of the mass-interaction pipeline.
- Per item, issues two read addresses: self index and linked-neighbour index.
- Writes the datapath result back after a fixed pipeline latency.
- State RAM is ping-pong banked: reads from the current bank, writes to the other, so there is no read-after-write hazard. Also arbitrates host configuration writes onto the single RAM write port.

Parameters:
SIZE, 27, RAM word width (bits)
ADDR_WIDTH, 4, item index width; RAM address width is ADDR_WIDTH+1 (MSB = bank)
PIPE_LAT, 3, cycles from read address issue to valid datapath result; legal range 1..8

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
sample_tick  in  1  single-cycle pass request
num_active  in  ADDR_WIDTH+1  item count; sampled at pass start
link_idx  in  ADDR_WIDTH  neighbour index of cur_idx (combinational link table lookup)
pipe_result  in  SIZE  datapath result, valid PIPE_LAT cycles after issue
host_we  in  1  host write request
host_addr  in  ADDR_WIDTH  host item index
host_data  in  SIZE  host write data
cur_idx  out  ADDR_WIDTH  item currently issued
rd_addr_a  out  ADDR_WIDTH+1  RAM read port 1 address {bank_sel, cur_idx}
rd_addr_b  out  ADDR_WIDTH+1  RAM read port 2 address {bank_sel, link_idx}
rd_valid  out  1  high in ISSUE cycles
ram_we  out  1  RAM write enable
ram_w_addr  out  ADDR_WIDTH+1  RAM write address
ram_d  out  SIZE  RAM write data
host_ack  out  1  host write accepted this cycle
busy  out  1  state != IDLE
done  out  1  one-cycle pass-complete pulse
bank_sel  out  1  current read bank
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset: state IDLE, cur_idx=0, bank_sel=0, count=0, pending=0, writeback shift register cleared, done=0, overrun=0, busy=0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - host_we=1: host_ack=1 the same cycle (combinational); ram_we=1, ram_w_addr={bank_sel, host_addr}, ram_d=host_data.
  - sample_tick with host_we in the same cycle: host write wins; tick is stored in pending and the pass starts next cycle.
  - tick or pending with no host_we: latch count=min(num_active, 2**ADDR_WIDTH), clear pending, go to ISSUE with cur_idx=0. If count=0, go directly to DONE.
- ISSUE:
  - One item per cycle. rd_valid=1; push {1, cur_idx} into a PIPE_LAT-deep valid/index shift register.
  - cur_idx increments; after item count-1 go to DRAIN.
- Writeback: when the shift register output is valid, ram_we=1, ram_w_addr={~bank_sel, idx}, ram_d=pipe_result. Item issued in cycle c is written in cycle c+PIPE_LAT.
- DRAIN: wait until the shift register is empty, then go to DONE.
- DONE: done=1 for one cycle; bank_sel toggles at the end of the cycle; cur_idx returns to 0; go to IDLE.
- Timing: tick sampled in cycle T gives ISSUE cycles T+1..T+N. Last write at T+N+PIPE_LAT. done at T+N+PIPE_LAT+1. busy falls the cycle after done.
- Host writes outside IDLE: host_ack=0; the host holds host_we until acked. The host never touches the write port during a pass.
- Tick while busy: dropped; overrun set (sticky until reset). pending is not set.
- Reset mid-pass: immediate abort; in-flight writes are discarded; bank_sel returns to 0.
- rd_addr_a/rd_addr_b: driven from registered state; don't-care when rd_valid=0.

Optional Feature:
- Macro DROP_COUNT_EN.
- When defined: add output drop_count (8 bits). It increments on every dropped tick, saturates at 255, and clears on reset.
- When undefined: port and logic are absent; only the overrun flag exists.

Test Plan:
- Reset, then tick with num_active=4, PIPE_LAT=3, link_idx=cur_idx+1: rd_addr_a=0..3 in cycles T+1..T+4; writes to addresses 16..19 at T+4..T+7; done at T+8; bank_sel=1 afterwards.
- Second tick after the first pass: reads use bank 1 (rd_addr_a=16..19); writes go to 0..3; bank_sel returns to 0.
- host_we with host_addr=5 and sample_tick in the same IDLE cycle: host_ack=1, write to address 5 (bank 0); pass starts the next cycle.
- num_active=0: done pulses at T+1; no ram_we; bank_sel toggles. num_active=20: 16 items issued.
- Tick during ISSUE: ignored; overrun=1; pass completes normally. With DROP_COUNT_EN, drop_count=1.
- reset_n asserted mid-DRAIN: ram_we drops immediately; all outputs at reset values; next tick starts cleanly from bank 0.

Source files
------------

// File: rtl/mass_pass_scheduler.sv
// Mass-update pass sequencer: issues self/neighbour reads per item, writes results into the opposite
// ping-pong bank after PIPE_LAT cycles, and arbitrates host writes. Define DROP_COUNT_EN for drop_count.
module mass_pass_scheduler #(
  parameter int SIZE       = 27,
  parameter int ADDR_WIDTH = 4,
  parameter int PIPE_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_tick,
  input  logic [ADDR_WIDTH:0]   num_active,
  input  logic [ADDR_WIDTH-1:0] link_idx,
  input  logic [SIZE-1:0]       pipe_result,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [SIZE-1:0]       host_data,
  output logic [ADDR_WIDTH-1:0] cur_idx,
  output logic [ADDR_WIDTH:0]   rd_addr_a,
  output logic [ADDR_WIDTH:0]   rd_addr_b,
  output logic                  rd_valid,
  output logic                  ram_we,
  output logic [ADDR_WIDTH:0]   ram_w_addr,
  output logic [SIZE-1:0]       ram_d,
  output logic                  host_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  bank_sel,
  output logic                  overrun
`ifdef DROP_COUNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  localparam logic [ADDR_WIDTH:0] MAX_ITEMS = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_idx_q, cur_idx_d;
  logic                  bank_sel_q, bank_sel_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic [PIPE_LAT-1:0]   wb_valid_q, wb_valid_d;
  logic [ADDR_WIDTH-1:0] wb_idx_q [PIPE_LAT];
  logic [ADDR_WIDTH-1:0] wb_idx_d [PIPE_LAT];
  logic                  tick_dropped;
  logic                  last_item;

  assign tick_dropped = sample_tick && (state_q != S_IDLE);
  assign last_item    = ({1'b0, cur_idx_q} == (count_q - (ADDR_WIDTH+1)'(1)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the index stages are reset too, so an aborted pass leaves no stale writeback behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cur_idx_q  <= '0;
      bank_sel_q <= 1'b0;
      count_q    <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      wb_valid_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) wb_idx_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      bank_sel_q <= bank_sel_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      wb_valid_q <= wb_valid_d;
      for (int i = 0; i < PIPE_LAT; i++) wb_idx_q[i] <= wb_idx_d[i];
    end
  end

  // Writeback delay line: an item issued in cycle c reaches the last stage in cycle c+PIPE_LAT.
  always_comb begin
    wb_valid_d[0] = (state_q == S_ISSUE);
    wb_idx_d[0]   = cur_idx_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      wb_valid_d[i] = wb_valid_q[i-1];
      wb_idx_d[i]   = wb_idx_q[i-1];
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    bank_sel_d = bank_sel_q;
    count_d    = count_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q | tick_dropped;
    unique case (state_q)
      S_IDLE: begin
        if (host_we) begin
          if (sample_tick) pending_d = 1'b1;
        end else if (sample_tick || pending_q) begin
          pending_d = 1'b0;
          count_d   = (num_active > MAX_ITEMS) ? MAX_ITEMS : num_active;
          cur_idx_d = '0;
          state_d   = (count_d == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        cur_idx_d = cur_idx_q + ADDR_WIDTH'(1);
        if (last_item) state_d = S_DRAIN;
      end
      // Leave once only the final write remains, so done lands one cycle after it.
      S_DRAIN: if (wb_valid_d == '0) state_d = S_DONE;
      S_DONE: begin
        bank_sel_d = ~bank_sel_q;
        cur_idx_d  = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_valid   = (state_q == S_ISSUE);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    host_ack   = (state_q == S_IDLE) && host_we;
    ram_we     = 1'b0;
    ram_w_addr = {bank_sel_q, host_addr};
    ram_d      = host_data;
    if (wb_valid_q[PIPE_LAT-1]) begin
      ram_we     = 1'b1;
      ram_w_addr = {~bank_sel_q, wb_idx_q[PIPE_LAT-1]};
      ram_d      = pipe_result;
    end else if (host_ack) begin
      ram_we     = 1'b1;
    end
  end

  assign cur_idx   = cur_idx_q;
  assign rd_addr_a = {bank_sel_q, cur_idx_q};
  assign rd_addr_b = {bank_sel_q, link_idx};
  assign bank_sel  = bank_sel_q;
  assign overrun   = overrun_q;

`ifdef DROP_COUNT_EN
  logic [7:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (tick_dropped && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_count_q <= 8'd0;
    else          drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_mass_pass_scheduler.sv
// Testbench for mass_pass_scheduler: table-driven passes plus randomized passes and host writes,
// checked against a per-cycle schedule derived arithmetically from the tick cycle.
module tb_mass_pass_scheduler;
  localparam int AW = 4;
  localparam int SZ = 27;
  localparam int P  = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sample_tick;
  logic [AW:0]   num_active;
  logic [AW-1:0] link_idx;
  logic [SZ-1:0] pipe_result;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [SZ-1:0] host_data;
  logic [AW-1:0] cur_idx;
  logic [AW:0]   rd_addr_a, rd_addr_b, ram_w_addr;
  logic          rd_valid, ram_we, host_ack, busy, done, bank_sel, overrun;
  logic [SZ-1:0] ram_d;
`ifdef DROP_COUNT_EN
  logic [7:0]    drop_count;
`endif

  logic [AW-1:0] link_tab [16];
  assign link_idx = link_tab[cur_idx];

  always #5 clk = ~clk;

  mass_pass_scheduler #(.SIZE(SZ), .ADDR_WIDTH(AW), .PIPE_LAT(P)) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .num_active(num_active),
    .link_idx(link_idx), .pipe_result(pipe_result), .host_we(host_we), .host_addr(host_addr),
    .host_data(host_data), .cur_idx(cur_idx), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_valid(rd_valid), .ram_we(ram_we), .ram_w_addr(ram_w_addr), .ram_d(ram_d),
    .host_ack(host_ack), .busy(busy), .done(done), .bank_sel(bank_sel), .overrun(overrun)
`ifdef DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  typedef struct {
    int            num;        // num_active presented with the tick
    int            items;      // expected items issued
    int            done_k;     // expected done cycle, relative to the tick-sampling cycle
    int            drop_at;    // cycle offset of an extra tick during the pass (0 = none)
    bit            host_first; // host write and tick in the same IDLE cycle
    bit            host_hold;  // host holds host_we throughout the pass
    int            abort_at;   // cycle offset at which reset_n is pulsed (0 = none)
    logic [AW-1:0] h_addr;
  } vec_t;

  vec_t vecs [9];
  int   n_checks = 0;
  int   n_err    = 0;
  logic model_bank;
  bit   model_ovr;
  int   model_drops;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_sample();
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " bank_sel"}, 64'(bank_sel), 64'd0);
    check({tag, " overrun"}, 64'(overrun), 64'd0);
    check({tag, " ram_we"}, 64'(ram_we), 64'd0);
    check({tag, " rd_valid"}, 64'(rd_valid), 64'd0);
    check({tag, " cur_idx"}, 64'(cur_idx), 64'd0);
`ifdef DROP_COUNT_EN
    check({tag, " drop_count"}, 64'(drop_count), 64'd0);
`endif
  endtask

  task automatic host_write();
    logic [AW-1:0] a = AW'($urandom);
    logic [SZ-1:0] d = SZ'($urandom);
    cycle_begin();
    host_we = 1'b1; sample_tick = 1'b0; host_addr = a; host_data = d;
    cycle_sample();
    check("hw host_ack", 64'(host_ack), 64'd1);
    check("hw ram_we", 64'(ram_we), 64'd1);
    check("hw ram_w_addr", 64'(ram_w_addr), 64'({model_bank, a}));
    check("hw ram_d", 64'(ram_d), 64'(d));
    cycle_begin();
    host_we = 1'b0;
    cycle_sample();
    check("hw idle ram_we", 64'(ram_we), 64'd0);
  endtask

  task automatic do_pass(input vec_t v);
    logic [SZ-1:0] hd = SZ'($urandom);
    if (v.host_first) begin
      cycle_begin();
      host_we = 1'b1; host_addr = v.h_addr; host_data = hd;
      sample_tick = 1'b1; num_active = (AW+1)'(v.num);
      cycle_sample();
      check("hf host_ack", 64'(host_ack), 64'd1);
      check("hf ram_we", 64'(ram_we), 64'd1);
      check("hf ram_w_addr", 64'(ram_w_addr), 64'({model_bank, v.h_addr}));
      check("hf ram_d", 64'(ram_d), 64'(hd));
      cycle_begin();
      host_we = 1'b0; sample_tick = 1'b0;
      cycle_sample();
      check("hf pending busy", 64'(busy), 64'd0);
      check("hf pending ram_we", 64'(ram_we), 64'd0);
    end else begin
      cycle_begin();
      host_we = 1'b0; sample_tick = 1'b1; num_active = (AW+1)'(v.num);
      cycle_sample();
      check("tick busy", 64'(busy), 64'd0);
    end
    for (int k = 1; k <= v.done_k + 1; k++) begin
      cycle_begin();
      sample_tick = (k == v.drop_at);
      num_active  = (AW+1)'($urandom);
      pipe_result = SZ'($urandom);
      host_we     = v.host_hold;
      host_addr   = v.h_addr;
      host_data   = hd;
      cycle_sample();
      if (k <= v.done_k) begin
        check($sformatf("busy k=%0d", k), 64'(busy), 64'd1);
        check($sformatf("done k=%0d", k), 64'(done), 64'(k == v.done_k));
        check($sformatf("host_ack k=%0d", k), 64'(host_ack), 64'd0);
        check($sformatf("bank_sel k=%0d", k), 64'(bank_sel), 64'(model_bank));
        check($sformatf("rd_valid k=%0d", k), 64'(rd_valid), 64'(k <= v.items));
        if (k <= v.items) begin
          check($sformatf("cur_idx k=%0d", k), 64'(cur_idx), 64'(k - 1));
          check($sformatf("rd_addr_a k=%0d", k), 64'(rd_addr_a), 64'({model_bank, AW'(k - 1)}));
          check($sformatf("rd_addr_b k=%0d", k), 64'(rd_addr_b), 64'({model_bank, link_tab[k-1]}));
        end
        check($sformatf("ram_we k=%0d", k), 64'(ram_we), 64'((k > P) && (k <= v.items + P)));
        if ((k > P) && (k <= v.items + P)) begin
          check($sformatf("ram_w_addr k=%0d", k), 64'(ram_w_addr), 64'({~model_bank, AW'(k - P - 1)}));
          check($sformatf("ram_d k=%0d", k), 64'(ram_d), 64'(pipe_result));
        end
      end else begin
        model_bank = ~model_bank;
        check("end busy", 64'(busy), 64'd0);
        check("end done", 64'(done), 64'd0);
        check("end bank_sel", 64'(bank_sel), 64'(model_bank));
        check("end overrun", 64'(overrun), 64'(model_ovr));
`ifdef DROP_COUNT_EN
        check("end drop_count", 64'(drop_count), 64'(model_drops));
`endif
        check("end host_ack", 64'(host_ack), 64'(v.host_hold));
        check("end ram_we", 64'(ram_we), 64'(v.host_hold));
        if (v.host_hold) check("end ram_w_addr", 64'(ram_w_addr), 64'({model_bank, v.h_addr}));
      end
      if (k == v.drop_at) begin
        model_ovr = 1'b1;
        if (model_drops < 255) model_drops++;
      end
      if (k == v.abort_at) begin
        #1 reset_n = 1'b0;
        #1;
        model_bank = 1'b0; model_ovr = 1'b0; model_drops = 0;
        check_reset_state("abort");
        #1 reset_n = 1'b1;
        sample_tick = 1'b0; host_we = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; sample_tick = 1'b0; num_active = '0; pipe_result = '0;
    host_we = 1'b0; host_addr = '0; host_data = '0;
    model_bank = 1'b0; model_ovr = 1'b0; model_drops = 0;
    for (int i = 0; i < 16; i++) link_tab[i] = AW'(i + 1);

    //          num items done drop hf    hh    abort addr
    vecs[0] = '{4,   4,    8,   0,   1'b0, 1'b0, 0,    4'd0};
    vecs[1] = '{4,   4,    8,   0,   1'b0, 1'b0, 0,    4'd0};
    vecs[2] = '{3,   3,    7,   0,   1'b1, 1'b0, 0,    4'd5};
    vecs[3] = '{0,   0,    1,   0,   1'b0, 1'b0, 0,    4'd0};
    vecs[4] = '{20,  16,   20,  0,   1'b0, 1'b0, 0,    4'd0};
    vecs[5] = '{7,   7,    11,  2,   1'b0, 1'b1, 0,    4'd9};
    vecs[6] = '{4,   4,    8,   0,   1'b0, 1'b0, 6,    4'd0};
    vecs[7] = '{16,  16,   20,  5,   1'b0, 1'b0, 0,    4'd0};
    vecs[8] = '{1,   1,    5,   1,   1'b0, 1'b0, 0,    4'd0};

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    check("reset host_ack", 64'(host_ack), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) do_pass(vecs[i]);

    for (int r = 0; r < 24; r++) begin
      vec_t v;
      for (int i = 0; i < 16; i++) link_tab[i] = AW'($urandom);
      v.num        = int'($urandom_range(0, 24));
      v.items      = (v.num > 16) ? 16 : v.num;
      v.done_k     = (v.items == 0) ? 1 : v.items + P + 1;
      v.drop_at    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, v.done_k)) : 0;
      v.host_first = 1'($urandom_range(0, 1));
      v.host_hold  = 1'($urandom_range(0, 1));
      v.abort_at   = 0;
      v.h_addr     = AW'($urandom);
      repeat ($urandom_range(0, 2)) host_write();
      do_pass(v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
